// File: rtl/cdc_hs_sender_if.sv
// Bundle between local logic, the cdc_hs_sender block and the destination domain.
// master: the surrounding environment; slave: the sender block itself.
interface cdc_hs_sender_if #(
  parameter int DATA_LEN = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_data;
  logic                cdc_req;
  logic [DATA_LEN-1:0] cdc_data;
  logic                cdc_ack;
  logic                done;
  logic                busy;
  logic                timeout_err;
  logic                err_clr;

  modport master (
    output in_valid, in_data, cdc_ack, err_clr,
    input  in_ready, cdc_req, cdc_data, done, busy, timeout_err
  );

  modport slave (
    input  in_valid, in_data, cdc_ack, err_clr,
    output in_ready, cdc_req, cdc_data, done, busy, timeout_err
  );
endinterface

// File: rtl/cdc_hs_sender.sv
// Source-domain end of a 4-phase req/ack CDC handshake: accepts one word, holds it
// on cdc_data with a level request, and waits for the synchronised ack to rise and fall.
module cdc_hs_sender #(
  parameter int DATA_LEN    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic            clk,
  input  logic            rst,
  cdc_hs_sender_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_req;
  logic [DATA_LEN-1:0]   r_data;
  logic                  r_done;
  logic                  r_err;

  logic w_ack_s;
  logic w_in_ready;
  logic w_phase_stay;
  logic w_cnt_inc;
  logic w_cnt_hit;

  // cdc_ack is asynchronous: this chain is the only place it is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.cdc_ack};
    end
  end

  assign w_ack_s    = r_sync[SYNC_STAGES-1];
  assign w_in_ready = (r_state == S_IDLE) && !w_ack_s;

  // Counter only advances while a phase is still waiting; leaving a phase clears it instead.
  assign w_phase_stay = ((r_state == S_REQ) && !w_ack_s) || ((r_state == S_DROP) && w_ack_s);
  assign w_cnt_inc    = (TIMEOUT != 0) && w_phase_stay && (r_cnt != CNT_MAX);
  assign w_cnt_hit    = w_cnt_inc && (CNT_W'(r_cnt + 1'b1) == CNT_MAX);

  // NOTE: all state below updates with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_cnt_inc) begin
        r_cnt <= CNT_W'(r_cnt + 1'b1);
      end

      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            r_state <= S_REQ;
            r_data  <= bus.in_data;
            r_req   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (w_ack_s) begin
            r_state <= S_DROP;
            r_req   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_DROP: begin
          if (!w_ack_s) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase

      // A timeout reached in the same cycle as err_clr must not be lost.
      if (w_cnt_hit) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.cdc_req     = r_req;
  assign bus.cdc_data    = r_data;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_err;

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Self-checking bench for cdc_hs_sender (SYNC_STAGES=2, TIMEOUT=4) with a word scoreboard
// that is checked whenever cdc_req rises, plus per-scenario timing checks.
module tb_cdc_hs_sender;

  logic clk;
  logic rst;
  logic loop_en;
  logic ack_drv;

  int checks = 0;
  int errors = 0;
  int done_total = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       prev_req;
  logic       prev_busy;
  logic [7:0] prev_data;

  cdc_hs_sender_if #(.DATA_LEN(8)) bus();

  assign bus.cdc_ack = loop_en ? bus.cdc_req : ack_drv;

  cdc_hs_sender #(
    .DATA_LEN    (8),
    .SYNC_STAGES (2),
    .TIMEOUT     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / stability monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_req  = 1'b0;
      prev_busy = 1'b0;
      prev_data = '0;
    end else begin
      if (bus.done === 1'b1) done_total++;
      if (bus.cdc_req === 1'b1 && !prev_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: cdc_data=%h with no expected word", bus.cdc_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.cdc_data !== mon_exp) begin
            errors++;
            $display("FAIL scoreboard_data: got %h expected %h", bus.cdc_data, mon_exp);
          end
        end
      end
      if (prev_busy && bus.busy === 1'b1) begin
        checks++;
        if (bus.cdc_data !== prev_data) begin
          errors++;
          $display("FAIL data_stable: cdc_data moved %h -> %h during handshake", prev_data, bus.cdc_data);
        end
      end
      prev_req  = (bus.cdc_req === 1'b1);
      prev_busy = (bus.busy === 1'b1);
      prev_data = bus.cdc_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a word and returns 1 time unit after the edge that accepted it.
  task automatic send_word(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.in_ready === 1'b1) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_word: word %h never accepted within 40 cycles", d);
    end
  endtask

  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max && n < 0; i++) begin
      tick();
      if (bus.done === 1'b1) n = i;
    end
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", max);
    end else begin
      tick();
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL done_width: done=%b one cycle after pulse, expected 0", bus.done);
      end
    end
  endtask

  task automatic wait_drop();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (bus.busy === 1'b1 && bus.cdc_req === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_drop: DROP phase not reached within 30 cycles");
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [11:0] obs;
    obs = {bus.cdc_req, bus.cdc_data, bus.done, bus.busy, bus.timeout_err};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL %s: req/data/done/busy/err = %h, expected 000", name, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    check_outputs_zero("reset_outputs");
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b expected 1", bus.in_ready);
    end
    #10;
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_loopback();
    int done_n;
    int acc_n;
    int n2;
    logic pre;
    loop_en = 1'b1;
    send_word(8'hA5);
    checks++;
    if (bus.cdc_data !== 8'hA5 || bus.cdc_req !== 1'b1) begin
      errors++;
      $display("FAIL loop_accept: data=%h req=%b expected A5/1", bus.cdc_data, bus.cdc_req);
    end
    exp_q.push_back(8'h5A);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    done_n = 0;
    acc_n  = 0;
    for (int n = 1; n <= 20 && acc_n == 0; n++) begin
      pre = bus.in_ready;
      tick();
      if (bus.done === 1'b1 && done_n == 0) done_n = n;
      if (pre === 1'b1) acc_n = n;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (done_n != 6) begin
      errors++;
      $display("FAIL loop_done_latency: %0d cycles, expected 6", done_n);
    end
    checks++;
    if (acc_n != 7) begin
      errors++;
      $display("FAIL loop_next_accept: %0d cycles, expected 7", acc_n);
    end
    wait_done(20, n2);
    checks++;
    if (n2 != 6) begin
      errors++;
      $display("FAIL loop_second_done: %0d cycles, expected 6", n2);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    int n;
    loop_en = 1'b1;
    start = done_total;
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    wait_done(20, n);
    repeat (4) tick();
    checks++;
    if (done_total - start != 3) begin
      errors++;
      $display("FAIL b2b_done_count: %0d pulses, expected 3", done_total - start);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_queue: %0d words never sent, expected 0", exp_q.size());
    end
  endtask

  task automatic test_spurious_ack();
    int acc_n;
    int n;
    logic pre;
    loop_en = 1'b0;
    ack_drv = 1'b1;
    repeat (4) tick();
    exp_q.push_back(8'h77);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL spurious_block: ready=%b busy=%b expected 0/0", bus.in_ready, bus.busy);
      end
    end
    ack_drv = 1'b0;
    acc_n = 0;
    for (int k = 1; k <= 10 && acc_n == 0; k++) begin
      pre = bus.in_ready;
      tick();
      if (pre === 1'b1) acc_n = k;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc_n != 3) begin
      errors++;
      $display("FAIL spurious_release: accept %0d cycles after ack drop, expected 3", acc_n);
    end
    ack_drv = 1'b1;
    wait_drop();
    ack_drv = 1'b0;
    wait_done(20, n);
  endtask

  task automatic test_timeout();
    int n;
    loop_en = 1'b0;
    ack_drv = 1'b0;
    send_word(8'h96);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) begin
        checks++;
        if (bus.timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: err=%b after 3 cycles, expected 0", bus.timeout_err);
        end
      end
    end
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set: err=%b after 4 cycles, expected 1", bus.timeout_err);
    end
    ack_drv = 1'b1;
    wait_drop();
    ack_drv = 1'b0;
    wait_done(20, n);
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b after done, expected 1", bus.timeout_err);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%b after err_clr, expected 0", bus.timeout_err);
    end
    bus.err_clr = 1'b1;
    send_word(8'h69);
    repeat (4) tick();
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set_wins: err=%b with err_clr held, expected 1", bus.timeout_err);
    end
    bus.err_clr = 1'b0;
    ack_drv = 1'b1;
    wait_drop();
    ack_drv = 1'b0;
    wait_done(20, n);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    loop_en = 1'b0;
    ack_drv = 1'b0;
    send_word(8'hC3);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_in_req");
    #2;
    rst = 1'b0;
    tick();
    send_word(8'hE1);
    ack_drv = 1'b1;
    wait_drop();
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_in_drop");
    ack_drv = 1'b0;
    #2;
    rst = 1'b0;
    repeat (2) tick();
    loop_en = 1'b1;
    send_word(8'h3C);
    checks++;
    if (bus.cdc_data !== 8'h3C || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: data=%h busy=%b expected 3C/1", bus.cdc_data, bus.busy);
    end
    wait_done(20, n);
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL reset_recover_done: %0d cycles, expected 6", n);
    end
  endtask

  initial begin
    rst          = 1'b1;
    loop_en      = 1'b0;
    ack_drv      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.err_clr  = 1'b0;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_spurious_ack();
    test_timeout();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d words never seen on cdc_data", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
